// File: rtl/encoder_pkg.sv
// Shared widths and reset constants for the registered priority encoder.
package encoder_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 3;

    // Index value presented while no request is encoded (reset or empty input).
    localparam logic [OUT_W_DEF-1:0] IDX_RST = '0;

endpackage

// File: rtl/encoder_prio_enc_comb.sv
// Combinational highest-set-bit finder; adds a multi-hot flag when ENCODER_ONEHOT_ERR_EN is defined.
module prio_enc_comb #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] idx,
    output logic             any
`ifdef ENCODER_ONEHOT_ERR_EN
    ,
    output logic             multi
`endif
);

    logic [IN_W-1:0] win;

    // A bit wins when it is set and no higher-index bit is set.
    generate
        for (genvar gi = 0; gi < IN_W; gi++) begin : g_win
            if (gi == IN_W - 1) begin : g_top
                assign win[gi] = in[gi];
            end else begin : g_low
                assign win[gi] = in[gi] && (in[IN_W-1:gi+1] == '0);
            end
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (win[i]) begin
                idx = idx | OUT_W'(i);
            end
        end
    end

    assign any = |in;

`ifdef ENCODER_ONEHOT_ERR_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (in & (in - IN_W'(1))) != '0;
`endif

endmodule

// File: rtl/encoder.sv
// Registered 8-to-3 priority encoder with enable/hold; optional err output under ENCODER_ONEHOT_ERR_EN.
module encoder
    import encoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             e,
    output logic [OUT_W-1:0] out,
    output logic             valid
`ifdef ENCODER_ONEHOT_ERR_EN
    ,
    output logic             err
`endif
);

    logic [OUT_W-1:0] idx_next;
    logic             any_next;
    logic [OUT_W-1:0] out_reg;
    logic             valid_reg;

`ifdef ENCODER_ONEHOT_ERR_EN
    logic multi_next;
    logic err_reg;
`endif

    prio_enc_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_prio (
        .in    (in),
        .idx   (idx_next),
        .any   (any_next)
`ifdef ENCODER_ONEHOT_ERR_EN
        ,
        .multi (multi_next)
`endif
    );

    // Reset dominates enable; with e low the registers simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= OUT_W'(IDX_RST);
            valid_reg <= 1'b0;
        end else if (e) begin
            out_reg   <= idx_next;
            valid_reg <= any_next;
        end
    end

`ifdef ENCODER_ONEHOT_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (e) begin
            err_reg <= multi_next;
        end
    end

    assign err = err_reg;
`endif

    assign out   = out_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_encoder.sv
// Directed self-checking bench for encoder; err checks compile in with ENCODER_ONEHOT_ERR_EN.
module tb_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in  = 8'h00;
    logic       e   = 1'b0;
    logic [2:0] out;
    logic       valid;
`ifdef ENCODER_ONEHOT_ERR_EN
    logic       err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    encoder dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .e     (e),
        .out   (out),
        .valid (valid)
`ifdef ENCODER_ONEHOT_ERR_EN
        ,
        .err   (err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; e = 1'b1; in = 8'h80;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            if (out !== 3'd0) $display("FAIL reset_out cycle %0d: got %0d expected 0", c, out);
            else pass_cnt++;
            total_cnt++;
            if (valid !== 1'b0) $display("FAIL reset_valid cycle %0d: got %b expected 0", c, valid);
            else pass_cnt++;
`ifdef ENCODER_ONEHOT_ERR_EN
            total_cnt++;
            if (err !== 1'b0) $display("FAIL reset_err cycle %0d: got %b expected 0", c, err);
            else pass_cnt++;
`endif
            $display("reset cycle %0d: out=%0d valid=%b", c, out, valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_onehot_sweep();
        logic [7:0] vec [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        logic [2:0] exp [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in = vec[i];
            step();
            total_cnt++;
            if (out !== exp[i]) $display("FAIL sweep_out in=%h: got %0d expected %0d", vec[i], out, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (valid !== 1'b1) $display("FAIL sweep_valid in=%h: got %b expected 1", vec[i], valid);
            else pass_cnt++;
`ifdef ENCODER_ONEHOT_ERR_EN
            total_cnt++;
            if (err !== 1'b0) $display("FAIL sweep_err in=%h: got %b expected 0", vec[i], err);
            else pass_cnt++;
`endif
            $display("sweep in=%h: out=%0d valid=%b", vec[i], out, valid);
        end
    endtask

    task automatic test_zero();
        e = 1'b1; in = 8'h00;
        step();
        total_cnt++;
        if (out !== 3'd0) $display("FAIL zero_out: got %0d expected 0", out);
        else pass_cnt++;
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL zero_valid: got %b expected 0", valid);
        else pass_cnt++;
        $display("zero in=00: out=%0d valid=%b", out, valid);
    endtask

    task automatic test_hold();
        e = 1'b1; in = 8'h10;
        step();
        total_cnt++;
        if (out !== 3'd4 || valid !== 1'b1) $display("FAIL hold_load: got out=%0d valid=%b expected out=4 valid=1", out, valid);
        else pass_cnt++;
        $display("hold load in=10: out=%0d valid=%b", out, valid);
        e = 1'b0; in = 8'h02;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            if (out !== 3'd4) $display("FAIL hold_out cycle %0d: got %0d expected 4", c, out);
            else pass_cnt++;
            total_cnt++;
            if (valid !== 1'b1) $display("FAIL hold_valid cycle %0d: got %b expected 1", c, valid);
            else pass_cnt++;
            $display("hold e=0 in=02 cycle %0d: out=%0d valid=%b", c, out, valid);
        end
        // Hold an empty result too: valid must stay low while disabled.
        e = 1'b1; in = 8'h00;
        step();
        e = 1'b0; in = 8'h08;
        step();
        total_cnt++;
        if (out !== 3'd0 || valid !== 1'b0) $display("FAIL hold_empty: got out=%0d valid=%b expected out=0 valid=0", out, valid);
        else pass_cnt++;
        $display("hold empty e=0 in=08: out=%0d valid=%b", out, valid);
    endtask

    task automatic test_multi_hot();
        e = 1'b1; in = 8'b0010_0110;
        step();
        total_cnt++;
        if (out !== 3'd5 || valid !== 1'b1) $display("FAIL multi_26: got out=%0d valid=%b expected out=5 valid=1", out, valid);
        else pass_cnt++;
`ifdef ENCODER_ONEHOT_ERR_EN
        total_cnt++;
        if (err !== 1'b1) $display("FAIL multi_err_26: got %b expected 1", err);
        else pass_cnt++;
`endif
        $display("multi in=26: out=%0d valid=%b", out, valid);
        in = 8'h01;
        step();
        total_cnt++;
        if (out !== 3'd0 || valid !== 1'b1) $display("FAIL multi_01: got out=%0d valid=%b expected out=0 valid=1", out, valid);
        else pass_cnt++;
`ifdef ENCODER_ONEHOT_ERR_EN
        total_cnt++;
        if (err !== 1'b0) $display("FAIL multi_err_01: got %b expected 0", err);
        else pass_cnt++;
`endif
        $display("multi in=01: out=%0d valid=%b", out, valid);
        in = 8'b1000_0101;
        step();
        total_cnt++;
        if (out !== 3'd7 || valid !== 1'b1) $display("FAIL multi_85: got out=%0d valid=%b expected out=7 valid=1", out, valid);
        else pass_cnt++;
        $display("multi in=85: out=%0d valid=%b", out, valid);
        in = 8'b0000_1011;
        step();
        total_cnt++;
        if (out !== 3'd3) $display("FAIL multi_0b: got out=%0d expected 3", out);
        else pass_cnt++;
        $display("multi in=0b: out=%0d valid=%b", out, valid);
    endtask

    task automatic test_reset_priority();
        e = 1'b1; in = 8'h40; rst = 1'b1;
        step();
        total_cnt++;
        if (out !== 3'd0 || valid !== 1'b0) $display("FAIL rstprio_rst: got out=%0d valid=%b expected out=0 valid=0", out, valid);
        else pass_cnt++;
        $display("rstprio rst=1 in=40: out=%0d valid=%b", out, valid);
        rst = 1'b0;
        step();
        total_cnt++;
        if (out !== 3'd6 || valid !== 1'b1) $display("FAIL rstprio_resume: got out=%0d valid=%b expected out=6 valid=1", out, valid);
        else pass_cnt++;
        $display("rstprio rst=0 in=40: out=%0d valid=%b", out, valid);
    endtask

    initial begin
        test_reset();
        test_onehot_sweep();
        test_zero();
        test_hold();
        test_multi_hot();
        test_reset_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
